// File: rtl/line_buffer_pkg.sv
// Shared definitions for the multi-line buffer: FSM state encoding and the
// helper that locates a tap slice inside the packed taps vector.
package line_buffer_pkg;

   typedef enum logic {
      ST_FILL   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   // LSB position of tap slice k inside a packed vector of data_width-bit slices
   function automatic int tap_lsb(input int k, input int data_width);
      return k * data_width;
   endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One image row of storage: DATA_WIDTH x IMG_WIDTH, combinational read,
// clocked write. A write and a read at the same address in one cycle return
// the old contents (read-before-write).
module line_buffer_ram
   import line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   localparam int PTR_W     = $clog2(IMG_WIDTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [PTR_W-1:0]      addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

   assign rdata = mem[addr];

   // Row storage write port.
   // NOTE: no reset on the array; contents before the first full row are don't-care and a reset would block RAM mapping.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/line_buffer_array.sv
// Multi-line buffer: keeps NUM_LINES rows in cascaded line memories and, for
// every accepted pixel, presents the NUM_LINES+1 pixel column (current pixel
// in slice 0, k rows above in slice k) one cycle later.
// Optional build macro LINE_BUFFER_ZERO_PAD_EN: emit a column for every pixel
// from row 0 onward, with rows that do not exist yet forced to zero.
module line_buffer_array
   import line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int NUM_LINES  = 2,
   localparam int PTR_W     = $clog2(IMG_WIDTH)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clear_i,
   input  logic                              valid_i,
   input  logic [DATA_WIDTH-1:0]             data_i,
   output logic                              valid_o,
   output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] taps_o,
   output logic [PTR_W-1:0]                  col_o,
   output logic                              fill_o
);

   localparam int ROW_W = $clog2(NUM_LINES + 1);
   localparam int TAP_W = (NUM_LINES + 1) * DATA_WIDTH;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(NUM_LINES);

   state_t                state, state_next;
   logic [PTR_W-1:0]      ptr, ptr_next;
   logic [ROW_W-1:0]      row, row_next;
   logic                  accept;
   logic                  wrap;
   logic                  valid_next;
   logic [TAP_W-1:0]      taps_next;
   logic [DATA_WIDTH-1:0] rd [NUM_LINES];
   logic [DATA_WIDTH-1:0] wd [NUM_LINES];

   // A clear in the same cycle drops the pixel.
   assign accept = valid_i && !clear_i;
   assign wrap   = (ptr == PTR_LAST);
   assign fill_o = (state == ST_FILL);

   // Line 0 takes the incoming pixel; each deeper line takes the old value of
   // the line above it, so the column shifts down one row per visit.
   for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
      if (k == 0) begin : g_head
         assign wd[k] = data_i;
      end else begin : g_cascade
         assign wd[k] = rd[k-1];
      end

      line_buffer_ram #(
         .DATA_WIDTH(DATA_WIDTH),
         .IMG_WIDTH (IMG_WIDTH)
      ) u_ram (
         .clk  (clk),
         .we   (accept),
         .addr (ptr),
         .wdata(wd[k]),
         .rdata(rd[k])
      );
   end

   // Next column pointer, saturating row counter and FILL/STREAM transition.
   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      ptr_next   = ptr;
      row_next   = row;
      state_next = state;
      if (clear_i) begin
         ptr_next   = '0;
         row_next   = '0;
         state_next = ST_FILL;
      end else if (valid_i) begin
         ptr_next = wrap ? '0 : ptr + 1'b1;
         if (wrap && row != ROW_FULL) row_next = row + 1'b1;
         if (state == ST_FILL && row_next == ROW_FULL) state_next = ST_STREAM;
      end
   end

   // Assemble the column for the pixel being accepted; zero when idle.
   always_comb begin
      taps_next  = '0;
      valid_next = 1'b0;
      if (accept) begin
         taps_next[DATA_WIDTH-1:0] = data_i;
         for (int k = 1; k <= NUM_LINES; k++) begin
            taps_next[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = rd[k-1];
`ifdef LINE_BUFFER_ZERO_PAD_EN
            // Rows above the top of the image read as zero padding.
            if (k > int'(row)) taps_next[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = '0;
`endif
         end
`ifdef LINE_BUFFER_ZERO_PAD_EN
         valid_next = 1'b1;
`else
         valid_next = (state == ST_STREAM);
`endif
      end
   end

   // State and output registers; column index holds across bubbles.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_FILL;
         ptr     <= '0;
         row     <= '0;
         valid_o <= 1'b0;
         taps_o  <= '0;
         col_o   <= '0;
      end else begin
         state   <= state_next;
         ptr     <= ptr_next;
         row     <= row_next;
         valid_o <= valid_next;
         taps_o  <= taps_next;
         if (clear_i)      col_o <= '0;
         else if (valid_i) col_o <= ptr;
      end
   end

endmodule

// File: tb/tb_line_buffer_array.sv
// Scoreboard bench for line_buffer_array (IMG_WIDTH=4, NUM_LINES=2, 8-bit).
// The reference model keeps the list of pixels accepted since the last
// clear/reset; the column for pixel n is pixel n - k*IMG_WIDTH in slice k.
module tb_line_buffer_array;

   localparam int DW    = 8;
   localparam int W     = 4;
   localparam int NL    = 2;
   localparam int PTR_W = $clog2(W);
   localparam int TAP_W = (NL + 1) * DW;

   typedef struct {
      logic             valid;
      logic [TAP_W-1:0] taps;
      logic             chk_taps;
      logic [PTR_W-1:0] col;
      logic             fill;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clear_i = 1'b0;
   logic             valid_i = 1'b0;
   logic [DW-1:0]    data_i = '0;
   logic             valid_o;
   logic [TAP_W-1:0] taps_o;
   logic [PTR_W-1:0] col_o;
   logic             fill_o;

   int               n_cmp = 0;
   int               n_err = 0;
   logic [DW-1:0]    hist[$];
   logic [PTR_W-1:0] last_col = '0;
   exp_t             sbq[$];

   line_buffer_array #(
      .DATA_WIDTH(DW),
      .IMG_WIDTH (W),
      .NUM_LINES (NL)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear_i(clear_i),
      .valid_i(valid_i),
      .data_i (data_i),
      .valid_o(valid_o),
      .taps_o (taps_o),
      .col_o  (col_o),
      .fill_o (fill_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, then record what the model says the DUT shows after that edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic clr);
      exp_t e;
      int   n;
      clear_i = clr;
      valid_i = v;
      data_i  = d;
      @(posedge clk);
      e.valid    = 1'b0;
      e.taps     = '0;
      e.chk_taps = 1'b1;
      if (clr) begin
         hist.delete();
         last_col = '0;
      end else if (v) begin
         n = hist.size();
         hist.push_back(d);
         last_col = PTR_W'(n % W);
`ifdef LINE_BUFFER_ZERO_PAD_EN
         e.valid = 1'b1;
`else
         e.valid = ((n / W) >= NL);
`endif
         for (int k = 0; k <= NL; k++)
            if (n - k * W >= 0) e.taps[k*DW +: DW] = hist[n - k * W];
         e.chk_taps = e.valid;
      end
      e.col  = last_col;
      e.fill = (hist.size() / W) < NL;
      sbq.push_back(e);
      #1;
   endtask

   // Monitor: one scoreboard entry per driven cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("valid_o", 64'(valid_o), 64'(e.valid));
         check("col_o", 64'(col_o), 64'(e.col));
         check("fill_o", 64'(fill_o), 64'(e.fill));
         if (e.chk_taps) check("taps_o", 64'(taps_o), 64'(e.taps));
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 64'(valid_o), 64'(0));
      check({tag, "_taps"}, 64'(taps_o), 64'(0));
      check({tag, "_col"}, 64'(col_o), 64'(0));
      check({tag, "_fill"}, 64'(fill_o), 64'(1));
   endtask

   initial begin
      // Cold reset
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill then stream, continuing into steady-state wraps
      for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0);

      // Same stream with a bubble after every pixel, including at the row wrap
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, DW'(i), 1'b0);
         step(1'b0, DW'($urandom), 1'b0);
      end

      // Clear mid-row colliding with a valid pixel, then refill
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b0);
      step(1'b1, 8'd10, 1'b1);
      for (int i = 20; i < 32; i++) step(1'b1, DW'(i), 1'b0);

      // Asynchronous reset between edges in the middle of a row
      for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 40), 1'b0);
      valid_i = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_state("async_reset");
      hist.delete();
      last_col = '0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 14; i++) step(1'b1, DW'(i + 60), 1'b0);

      // Randomized traffic with bubbles and occasional clears
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 299) == 0);

      step(1'b0, '0, 1'b0);
      @(negedge clk);
      #1 check("scoreboard_drained", 64'(sbq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
